// File: rtl/softusb_frame_sched.sv
// softusb USB frame scheduler: SOF timing, 11-bit frame number and two one-shot
// in-frame alarms, exposed as a 10-register window on the navigation CPU IO bus.
module softusb_frame_sched #(
    parameter logic [5:0]  BASE         = 6'h28,
    parameter logic [15:0] FRAME_CYCLES = 16'd48000
) (
    input  logic        usb_clk,
    input  logic        usb_rst_n,
    input  logic        io_we,
    input  logic [5:0]  io_a,
    input  logic [7:0]  io_di,
    output logic [7:0]  io_do,
    output logic        sof,
    output logic [10:0] frame_nr,
    output logic        irq
);

    localparam logic [15:0] LAST = FRAME_CYCLES - 16'd1;

    logic [5:0]  ctrl;
    logic [2:0]  status;
    logic [15:0] pos;
    logic [15:0] alarm0;
    logic [15:0] alarm1;
    logic [7:0]  pos_shadow;

    // Offset wraps modulo 64, so a single compare bounds the window.
    logic [5:0] off;
    logic       in_win;
    assign off    = io_a - BASE;
    assign in_win = off < 6'd10;

    logic wr;
    assign wr = io_we && in_win;

    logic en, wrap, m0, m1;
    assign en   = ctrl[0];
    assign wrap = en && (pos == LAST);
    assign m0   = en && ctrl[1] && (pos == alarm0) && (alarm0 < FRAME_CYCLES);
    assign m1   = en && ctrl[2] && (pos == alarm1) && (alarm1 < FRAME_CYCLES);

    logic [2:0] w1c;
    assign w1c = (wr && off == 6'd1) ? io_di[2:0] : 3'b000;

    logic [7:0] rd_mux;
    always_comb begin
        rd_mux = 8'h00;
        if (in_win) begin
            case (off)
                6'd0:    rd_mux = {2'b00, ctrl};
                6'd1:    rd_mux = {5'b0, status};
                6'd2:    rd_mux = frame_nr[7:0];
                6'd3:    rd_mux = {5'b0, frame_nr[10:8]};
                6'd4:    rd_mux = alarm0[7:0];
                6'd5:    rd_mux = alarm0[15:8];
                6'd6:    rd_mux = alarm1[7:0];
                6'd7:    rd_mux = alarm1[15:8];
                6'd8:    rd_mux = pos[7:0];
                6'd9:    rd_mux = pos_shadow;
                default: rd_mux = 8'h00;
            endcase
        end
    end

    always_ff @(posedge usb_clk or negedge usb_rst_n) begin
        if (!usb_rst_n) begin
            io_do      <= 8'h00;
            sof        <= 1'b0;
            frame_nr   <= 11'd0;
            irq        <= 1'b0;
            pos        <= 16'd0;
            ctrl       <= 6'd0;
            status     <= 3'd0;
            alarm0     <= 16'd0;
            alarm1     <= 16'd0;
            pos_shadow <= 8'h00;
        end else begin
            sof <= wrap;

            if (wr && off == 6'd0 && io_di[0] && !en)
                pos <= 16'd0;
            else if (wrap)
                pos <= 16'd0;
            else if (en)
                pos <= pos + 16'd1;

            // Later assignments win: hardware disarm beats a same-cycle re-arm.
            if (wr && off == 6'd0)
                ctrl <= io_di[5:0];
            if (m0)
                ctrl[1] <= 1'b0;
            if (m1)
                ctrl[2] <= 1'b0;

            status <= (status & ~w1c) | {m1, m0, wrap};
            irq    <= |(status & ctrl[5:3]);

            // A frame number write in the wrap cycle suppresses the increment.
            if (wr && (off == 6'd2 || off == 6'd3)) begin
                if (off == 6'd2)
                    frame_nr[7:0] <= io_di;
                else
                    frame_nr[10:8] <= io_di[2:0];
            end else if (wrap) begin
                frame_nr <= frame_nr + 11'd1;
            end

            if (wr && off == 6'd4) alarm0[7:0]  <= io_di;
            if (wr && off == 6'd5) alarm0[15:8] <= io_di;
            if (wr && off == 6'd6) alarm1[7:0]  <= io_di;
            if (wr && off == 6'd7) alarm1[15:8] <= io_di;

            io_do <= rd_mux;
            if (in_win && off == 6'd8)
                pos_shadow <= pos[15:8];
        end
    end

endmodule
